// File: rtl/bus_gnrtr_n_arbiter.sv
// Bus generator N-port arbiter.
// One independent IDLE -> POP -> PUSH arbiter per bus moves a packet from the
// granted driver port to its destination port(s), or to all ports on broadcast.
// Defining ARB_ROUND_ROBIN_EN selects round-robin arbitration; the default
// build uses fixed priority (lowest pending index wins).
module bus_gnrtr_n_arbiter #(
    parameter int         bits      = 1,
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [bits-1:0][drvrs-1:0]            pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0]            pop,
    output logic [bits-1:0][drvrs-1:0]            push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

    localparam int IDX_W = (drvrs > 1) ? $clog2(drvrs) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

    for (genvar b = 0; b < bits; b++) begin : g_bus
        state_t                        state;
        state_t                        state_nxt;
        logic [IDX_W-1:0]              winner;
        logic [IDX_W-1:0]              winner_nxt;
        logic                          any_pend;
        logic [pckg_sz-1:0]            pkt;
        logic [7:0]                    dest;
        logic [drvrs-1:0]              pop_b;
        logic [drvrs-1:0]              push_b;
        logic [drvrs-1:0][pckg_sz-1:0] dpush_b;

`ifdef ARB_ROUND_ROBIN_EN
        logic [IDX_W-1:0]              ptr;

        // Round robin: first pending port strictly after the last winner, wrapping.
        always_comb begin
            int idx;
            winner_nxt = '0;
            any_pend   = 1'b0;
            idx        = 0;
            for (int off = 1; off <= drvrs; off++) begin
                idx = int'(ptr) + off;
                if (idx >= drvrs) begin
                    idx = idx - drvrs;
                end
                if (!any_pend && pndng[b][IDX_W'(idx)]) begin
                    winner_nxt = IDX_W'(idx);
                    any_pend   = 1'b1;
                end
            end
        end
`else
        // Fixed priority: lowest-index pending port wins.
        always_comb begin
            winner_nxt = '0;
            any_pend   = 1'b0;
            for (int i = 0; i < drvrs; i++) begin
                if (!any_pend && pndng[b][i]) begin
                    winner_nxt = IDX_W'(i);
                    any_pend   = 1'b1;
                end
            end
        end
`endif

        // State, grant and packet registers; winner is frozen for the whole transfer.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state  <= IDLE;
                winner <= '0;
                pkt    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                ptr    <= '0;
`endif
            end else begin
                state <= state_nxt;
                if (state == IDLE && any_pend) begin
                    winner <= winner_nxt;
                end
                if (state == POP) begin
                    pkt <= D_pop[b][winner];
`ifdef ARB_ROUND_ROBIN_EN
                    ptr <= winner;
`endif
                end
            end
        end

        // Next-state: each transfer is exactly one POP and one PUSH cycle.
        always_comb begin
            state_nxt = state;
            case (state)
                IDLE:    if (any_pend) state_nxt = POP;
                POP:     state_nxt = PUSH;
                PUSH:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end

        assign dest = pkt[pckg_sz-1 -: 8];

        // Strobes and delivered data; everything is zero outside an active strobe.
        always_comb begin
            pop_b   = '0;
            push_b  = '0;
            dpush_b = '0;
            if (state == POP) begin
                pop_b[winner] = 1'b1;
            end
            if (state == PUSH) begin
                if (dest == broadcast) begin
                    push_b         = '1;
                    push_b[winner] = 1'b0;
                end else if (int'(dest) < drvrs) begin
                    push_b[dest[IDX_W-1:0]] = 1'b1;
                end
                if (|push_b) begin
                    dpush_b = {drvrs{pkt}};
                end
            end
        end

        assign pop[b]    = pop_b;
        assign push[b]   = push_b;
        assign D_push[b] = dpush_b;
    end

endmodule

// File: tb/tb_bus_gnrtr_n_arbiter.sv
// Bench for bus_gnrtr_n_arbiter (default parameters, one bus, four ports).
// Driver ports are FIFOs; a transaction-level model predicts pop/push/D_push.
module tb_bus_gnrtr_n_arbiter;

    localparam int NB = 1;
    localparam int ND = 4;
    localparam int PW = 16;

    logic clk = 1'b0;
    logic reset;
    logic [NB-1:0][ND-1:0]         pndng;
    logic [NB-1:0][ND-1:0][PW-1:0] D_pop;
    logic [NB-1:0][ND-1:0]         pop;
    logic [NB-1:0][ND-1:0]         push;
    logic [NB-1:0][ND-1:0][PW-1:0] D_push;

    bus_gnrtr_n_arbiter #(
        .bits(NB), .drvrs(ND), .pckg_sz(PW), .broadcast(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .push(push), .D_push(D_push)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // source FIFOs, one per driver port
    logic [PW-1:0] fifo [ND][16];
    int rd  [ND];
    int cnt [ND];
    logic [ND-1:0] deq;
    int en_pct = 0;

    // model state: granted port, cycle of its POP, round-robin pointer
    int g_port  = 0;
    int g_cycle = -10;
    int m_ptr   = 0;
    logic [ND-1:0]         exp_pop;
    logic [ND-1:0]         exp_push;
    logic [ND-1:0][PW-1:0] exp_d;

    bit log_on = 1'b0;
    int glog [$];
    int exp_order [5];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic put(input int p, input logic [PW-1:0] pk);
        if (cnt[p] < 16) begin
            fifo[p][(rd[p] + cnt[p]) % 16] = pk;
            cnt[p]++;
        end
    endtask

    function automatic logic [PW-1:0] rand_pkt();
        int r;
        logic [7:0] d;
        r = $urandom_range(0, 9);
        if (r < 4)      d = 8'(r);
        else if (r < 6) d = 8'hFF;
        else            d = 8'($urandom_range(4, 254));
        return {d, 8'($urandom)};
    endfunction

    function automatic int pick(input logic [ND-1:0] pv);
`ifdef ARB_ROUND_ROBIN_EN
        for (int off = 1; off <= ND; off++) begin
            if (pv[(m_ptr + off) % ND]) begin
                m_ptr = (m_ptr + off) % ND;
                return m_ptr;
            end
        end
`else
        for (int i = 0; i < ND; i++) begin
            if (pv[i]) return i;
        end
`endif
        return 0;
    endfunction

    task automatic drive();
        for (int p = 0; p < ND; p++) begin
            pndng[0][p] = (cnt[p] > 0);
            D_pop[0][p] = (cnt[p] > 0) ? fifo[p][rd[p]] : PW'($urandom);
        end
    endtask

    // Predict the outputs of the next cycle from the inputs just driven.
    task automatic model();
        logic [ND-1:0]         np;
        logic [ND-1:0]         npu;
        logic [ND-1:0][PW-1:0] nd;
        logic [PW-1:0]         pk;
        int dst;
        np  = '0;
        npu = '0;
        nd  = '0;
        if (cyc == g_cycle) begin
            pk  = D_pop[0][g_port];
            dst = int'(pk[PW-1 -: 8]);
            if (dst == 255) begin
                npu = '1;
                npu[g_port] = 1'b0;
            end else if (dst < ND) begin
                npu[dst] = 1'b1;
            end
            if (npu != '0) begin
                for (int k = 0; k < ND; k++) nd[k] = pk;
            end
        end
        if (cyc >= g_cycle + 2 && pndng[0] != '0) begin
            g_port  = pick(pndng[0]);
            g_cycle = cyc + 1;
            np[g_port] = 1'b1;
        end
        exp_pop  = np;
        exp_push = npu;
        exp_d    = nd;
    endtask

    // One clock cycle: check, update sources, drive, predict.
    task automatic step(input bit rst_level);
        bit was;
        @(negedge clk);
        cyc++;
        chk("pop",    64'(pop[0]),    64'(exp_pop));
        chk("push",   64'(push[0]),   64'(exp_push));
        chk("d_push", 64'(D_push[0]), 64'(exp_d));
        for (int p = 0; p < ND; p++) begin
            if (deq[p] && cnt[p] > 0) begin
                rd[p] = (rd[p] + 1) % 16;
                cnt[p]--;
            end
        end
        deq = pop[0];
        if (log_on) begin
            for (int p = 0; p < ND; p++) if (pop[0][p]) glog.push_back(p);
        end
        if (en_pct > 0) begin
            for (int p = 0; p < ND; p++) begin
                if ($urandom_range(0, 99) < en_pct && cnt[p] < 8) put(p, rand_pkt());
            end
        end
        drive();
        if (!rst_level) begin
            was   = reset;
            reset = 1'b0;
            if (was) begin
                #1;
                chk("rst_pop",    64'(pop[0]),    64'd0);
                chk("rst_push",   64'(push[0]),   64'd0);
                chk("rst_d_push", 64'(D_push[0]), 64'd0);
            end
            deq      = '0;
            g_cycle  = cyc - 10;
            m_ptr    = 0;
            exp_pop  = '0;
            exp_push = '0;
            exp_d    = '0;
        end else begin
            reset = 1'b1;
            model();
        end
    endtask

    initial begin
        bit hit;
        int got;
        reset    = 1'b1;
        pndng    = '0;
        D_pop    = '0;
        deq      = '0;
        exp_pop  = '0;
        exp_push = '0;
        exp_d    = '0;
        for (int p = 0; p < ND; p++) begin
            rd[p]  = 0;
            cnt[p] = 0;
        end
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{1, 2, 3, 0, 1};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0);
        for (int i = 0; i < 2; i++) step(1'b1);

        // single unicast, broadcast, invalid destination
        put(1, 16'h0312);
        for (int i = 0; i < 6; i++) step(1'b1);
        put(2, 16'hFFAB);
        for (int i = 0; i < 6; i++) step(1'b1);
        put(0, 16'h0755);
        for (int i = 0; i < 6; i++) step(1'b1);

        // back-to-back from one port
        put(1, 16'h0111);
        put(1, 16'h0222);
        for (int i = 0; i < 10; i++) step(1'b1);

        // reset dropped during the PUSH cycle
        put(3, 16'h0011);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            hit = (exp_push != '0);
            step(!hit);
        end
        chk("rst_reached_push", 64'(hit), 64'd1);
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < 6; i++) step(1'b1);

        // contention: all ports pending, pointer freshly reset
        for (int p = 0; p < ND; p++) begin
            for (int k = 0; k < 6; k++) put(p, rand_pkt());
        end
        log_on = 1'b1;
        for (int i = 0; i < 80; i++) step(1'b1);
        log_on = 1'b0;
        for (int i = 0; i < 5; i++) begin
            got = (i < glog.size()) ? glog[i] : -1;
            chk("grant_order", 64'(got), 64'(exp_order[i]));
        end

        // random traffic, then drain
        en_pct = 30;
        for (int i = 0; i < 1500; i++) step(1'b1);
        en_pct = 0;
        for (int i = 0; i < 200; i++) step(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_gnrtr_n_arbiter.md
BUS_GNRTR_N_ARBITER -- requirements
Module: bus_gnrtr_n_arbiter

Interface
REQ-001 SHALL have parameter bits, default 1: number of independent buses.
REQ-002 SHALL have parameter drvrs, default 4: number of driver/receiver ports per bus; legal range 2..255.
REQ-003 SHALL have parameter pckg_sz, default 16: packet width in bits; minimum 9.
REQ-004 SHALL have parameter broadcast, default 8'hFF: destination ID meaning "all ports".
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port pndng, input, [bits-1:0][drvrs-1:0]: port i on bus b has a packet waiting.
REQ-008 SHALL have port D_pop, input, [bits-1:0][drvrs-1:0][pckg_sz-1:0]: head packet of each port, valid while pndng is high.
REQ-009 SHALL have port pop, output, [bits-1:0][drvrs-1:0]: one-cycle dequeue strobe to the granted port.
REQ-010 SHALL have port push, output, [bits-1:0][drvrs-1:0]: one-cycle delivery strobe to destination port(s).
REQ-011 SHALL have port D_push, output, [bits-1:0][drvrs-1:0][pckg_sz-1:0]: delivered packet; every entry of bus b carries the same value.

Function
REQ-012 SHALL treat packet bits [pckg_sz-1:pckg_sz-8] as the destination ID; the remaining bits are payload and are forwarded unchanged.
REQ-013 SHALL run one identical, independent arbiter per bus index b.
REQ-014 SHALL use per-bus FSM states IDLE, POP, PUSH.
REQ-015 In IDLE with any pndng[b] bit high, SHALL latch the winner index and go to POP; otherwise SHALL stay in IDLE.
REQ-016 In POP, SHALL assert pop[b][winner] for exactly one cycle, capture D_pop[b][winner] into a packet register at the end of that cycle, and go to PUSH.
REQ-017 In PUSH, SHALL drive the captured packet on D_push[b] and assert push for exactly one cycle, then go to IDLE.
REQ-018 Latency: pndng high at edge N gives pop during cycle N+1 and push during cycle N+2; minimum spacing is 3 cycles per packet per bus.
REQ-019 For destination d < drvrs, SHALL assert only push[b][d]; d equal to the winner (self-send) SHALL be delivered normally.
REQ-020 For destination == broadcast, SHALL assert push[b][k] for every k except the winner.
REQ-021 For any other destination (>= drvrs and not broadcast), SHALL assert no push; the packet is dropped and the FSM returns to IDLE on schedule.
REQ-022 SHALL hold pop, push and D_push at 0 whenever their strobe is not active.
REQ-023 SHALL never assert more than one pop bit per bus in any cycle.
REQ-024 Arbitration SHALL be as selected in REQ-029 and REQ-030; pndng changes while in POP or PUSH SHALL NOT affect the current transfer.

Reset
REQ-025 While reset is low, SHALL immediately force pop=0, push=0, D_push=0, all FSMs to IDLE, the packet register to 0, and the round-robin pointer to 0.
REQ-026 Reset asserted during POP or PUSH SHALL abort the transfer: no push is issued after reset release.
REQ-027 On the first rising edge after reset goes high, SHALL evaluate pndng normally.

Configuration
REQ-028 SHALL use the macro ARB_ROUND_ROBIN_EN.
REQ-029 With ARB_ROUND_ROBIN_EN defined: the winner is the first pending port at or after pointer+1 (wrapping modulo drvrs), and the pointer is updated to the winner at POP.
REQ-030 Without ARB_ROUND_ROBIN_EN: fixed priority; the lowest-index pending port wins, and no pointer logic is present.

Verification
REQ-031 Single unicast: pndng[0][1]=1, D_pop[0][1]=16'h0312 -> pop[0][1] for one cycle, then push[0][3]=1 with D_push=16'h0312 one cycle later; no other push bits set.
REQ-032 Broadcast: port 2 sends 16'hFFAB -> push bits 0, 1 and 3 high in the same cycle with D_push=16'hFFAB; push[0][2]=0.
REQ-033 Invalid destination: port 0 sends 16'h0755 with drvrs=4 -> pop[0][0] pulses, no push, FSM back in IDLE 2 cycles after pop.
REQ-034 Contention: all four ports pending continuously, ARB_ROUND_ROBIN_EN defined -> grant order 1,2,3,0,1; without the macro -> port 0 granted every time.
REQ-035 Reset mid-transfer: drop reset low during the PUSH cycle -> push and D_push are 0 at once, and no delivery occurs after release.
REQ-036 Back-to-back: port 1 holds 2 packets -> pops are exactly 3 cycles apart, and both packets are delivered in order.
